// File: rtl/axil_if.sv
// AXI4-Lite bus bundle shared by the bridge (master) and its slave.
// Parameters: ADDR_WIDTH / DATA_WIDTH size the address and data buses.
// Modports: master drives AW/W/AR payload+valid and B/R ready;
//           slave drives the complementary signals.
interface axil_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_stream_bridge.sv
// Byte-stream to AXI4-Lite master bridge.
// Frames on the input stream: 'W' addr[4] data[4] or 'R' addr[4] (MSB first).
// Responses on the output stream: write -> {6'b0,bresp}; read -> {6'b0,rresp}
// then rdata MSB first; bad opcode -> 0xEE; inter-byte timeout -> 0xEF.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready command byte stream in
//   m_tdata/m_tvalid/m_tready response byte stream out
//   m_axil                   AXI4-Lite master
module axil_stream_bridge #(
    parameter int unsigned AXIL_ADDR_WIDTH = 32,
    parameter int unsigned AXIL_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    axil_if.master     m_axil
);

    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OpWrite     = 8'h57;
    localparam logic [7:0] OpRead      = 8'h52;
    localparam logic [7:0] RespBadOp   = 8'hEE;
    localparam logic [7:0] RespTimeout = 8'hEF;

    typedef enum logic [2:0] {
        StIdle, StAddr, StData, StWr, StBresp, StRd, StRdata, StTx
    } state_e;

    state_e                     state_q, state_d;
    logic                       is_write_q;
    logic [1:0]                 cnt_q;
    logic [AXIL_ADDR_WIDTH-1:0] addr_q;
    logic [AXIL_DATA_WIDTH-1:0] data_q;
    logic [39:0]                tx_buf_q;   // byte at [39:32] is the one on m_tdata
    logic [2:0]                 tx_len_q;   // bytes still to send
    logic [TimeoutW-1:0]        timeout_q;
    logic                       aw_done_q, w_done_q;

    logic s_hs, m_hs, aw_hs, w_hs, timeout_hit, op_valid;

    assign s_hs        = s_tvalid & s_tready;
    assign m_hs        = m_tvalid & m_tready;
    assign aw_hs       = m_axil.awvalid & m_axil.awready;
    assign w_hs        = m_axil.wvalid & m_axil.wready;
    assign timeout_hit = (timeout_q == TimeoutW'(TIMEOUT_CYCLES));
    assign op_valid    = (s_tdata == OpWrite) || (s_tdata == OpRead);

    assign m_tdata       = tx_buf_q[39:32];
    assign m_axil.awaddr = addr_q;
    assign m_axil.araddr = addr_q;
    assign m_axil.wdata  = data_q;
    assign m_axil.wstrb  = '1;
    assign m_axil.awprot = 3'b000;
    assign m_axil.arprot = 3'b000;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an accepted byte wins over a coincident timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (s_hs) state_d = op_valid ? StAddr : StTx;
            end
            StAddr: begin
                if (s_hs) begin
                    if (cnt_q == 2'd3) state_d = is_write_q ? StData : StRd;
                end else if (timeout_hit) begin
                    state_d = StTx;
                end
            end
            StData: begin
                if (s_hs) begin
                    if (cnt_q == 2'd3) state_d = StWr;
                end else if (timeout_hit) begin
                    state_d = StTx;
                end
            end
            StWr: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StBresp;
            end
            StBresp: if (m_axil.bvalid) state_d = StTx;
            StRd:    if (m_axil.arready) state_d = StRdata;
            StRdata: if (m_axil.rvalid) state_d = StTx;
            StTx:    if (m_hs && tx_len_q == 3'd1) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; s_tready is gated so it reads 0 for as long as reset is held
    always_comb begin
        s_tready       = 1'b0;
        m_tvalid       = 1'b0;
        m_axil.awvalid = 1'b0;
        m_axil.wvalid  = 1'b0;
        m_axil.bready  = 1'b0;
        m_axil.arvalid = 1'b0;
        m_axil.rready  = 1'b0;
        unique case (state_q)
            StIdle, StAddr, StData: s_tready = ~rst_i;
            StWr: begin
                m_axil.awvalid = ~aw_done_q;
                m_axil.wvalid  = ~w_done_q;
            end
            StBresp: m_axil.bready  = 1'b1;
            StRd:    m_axil.arvalid = 1'b1;
            StRdata: m_axil.rready  = 1'b1;
            StTx:    m_tvalid       = 1'b1;
            default: ;
        endcase
    end

    // Datapath: shift registers, counters, response buffer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            is_write_q <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            tx_buf_q   <= '0;
            tx_len_q   <= '0;
            timeout_q  <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q     <= '0;
                    timeout_q <= '0;
                    if (s_hs) begin
                        is_write_q <= (s_tdata == OpWrite);
                        if (!op_valid) begin
                            tx_buf_q <= {RespBadOp, 32'h0};
                            tx_len_q <= 3'd1;
                        end
                    end
                end
                StAddr, StData: begin
                    if (s_hs) begin
                        if (state_q == StAddr) begin
                            addr_q <= {addr_q[AXIL_ADDR_WIDTH-9:0], s_tdata};
                        end else begin
                            data_q <= {data_q[AXIL_DATA_WIDTH-9:0], s_tdata};
                        end
                        cnt_q     <= cnt_q + 2'd1;
                        timeout_q <= '0;
                    end else if (timeout_hit) begin
                        tx_buf_q  <= {RespTimeout, 32'h0};
                        tx_len_q  <= 3'd1;
                        timeout_q <= '0;
                    end else begin
                        timeout_q <= timeout_q + TimeoutW'(1);
                    end
                end
                StWr: begin
                    if (state_d != StWr) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        if (aw_hs) aw_done_q <= 1'b1;
                        if (w_hs)  w_done_q  <= 1'b1;
                    end
                end
                StBresp: begin
                    if (m_axil.bvalid) begin
                        tx_buf_q <= {6'b0, m_axil.bresp, 32'h0};
                        tx_len_q <= 3'd1;
                    end
                end
                StRdata: begin
                    if (m_axil.rvalid) begin
                        tx_buf_q <= {6'b0, m_axil.rresp, m_axil.rdata[31:0]};
                        tx_len_q <= 3'd5;
                    end
                end
                StTx: begin
                    if (m_hs) begin
                        tx_buf_q <= {tx_buf_q[31:0], 8'h00};
                        tx_len_q <= tx_len_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_stream_bridge.sv
// Directed bench for axil_stream_bridge with a small AXI-Lite slave model.
module tb_axil_stream_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b0;

    axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_stream_bridge #(
        .AXIL_ADDR_WIDTH(32),
        .AXIL_DATA_WIDTH(32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .s_tdata (s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .m_tdata (m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_axil  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model (all activity on negedge) ----------------
    logic [31:0] mem = '0;
    logic [31:0] aw_addr_seen = '0, w_data_seen = '0, ar_addr_seen = '0;
    logic [3:0]  w_strb_seen = '0;
    logic [2:0]  aw_prot_seen = '1, ar_prot_seen = '1;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_delay_en = 1'b0, r_hold = 1'b0;
    logic [1:0] bresp_cfg = 2'b00;
    bit aw_pend, w_pend, b_fire, r_pend, r_fire, w_got;
    int w_since;

    always @(negedge clk) begin
        if (rst) begin
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
            aw_pend = 0; w_pend = 0; b_fire = 0; r_pend = 0; r_fire = 0; w_got = 0; w_since = 0;
        end else begin
            // B first: it may only follow AW/W handshakes already completed
            if (b_fire) begin
                bus.bvalid = 1'b0; b_fire = 0;
            end else if (aw_pend && w_pend) begin
                bus.bvalid = 1'b1; bus.bresp = bresp_cfg;
            end
            if (bus.bvalid && bus.bready) begin
                b_fire = 1; aw_pend = 0; w_pend = 0; w_got = 0; b_cnt++;
            end
            // W
            if (w_got) w_since++;
            bus.wready = bus.wvalid;
            if (bus.wvalid && bus.wready) begin
                w_cnt++; w_data_seen = bus.wdata; w_strb_seen = bus.wstrb; mem = bus.wdata;
                w_pend = 1; w_got = 1; w_since = 0;
            end
            // AW, optionally held off until 5 cycles after the W handshake
            bus.awready = bus.awvalid && (!aw_delay_en || (w_got && w_since >= 5));
            if (bus.awvalid && bus.awready) begin
                aw_cnt++; aw_addr_seen = bus.awaddr; aw_prot_seen = bus.awprot; aw_pend = 1;
            end
            // R first, then AR
            if (r_fire) begin
                bus.rvalid = 1'b0; r_fire = 0;
            end else if (r_pend && !r_hold) begin
                bus.rvalid = 1'b1; bus.rdata = mem; bus.rresp = 2'b00;
            end
            if (bus.rvalid && bus.rready) begin
                r_fire = 1; r_pend = 0; r_cnt++;
            end
            bus.arready = bus.arvalid;
            if (bus.arvalid && bus.arready) begin
                ar_cnt++; ar_addr_seen = bus.araddr; ar_prot_seen = bus.arprot; r_pend = 1;
            end
        end
    end

    // ---------------- stream drivers (called at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        while (!s_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) check("s_tready_wait", 0, 1);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    logic [7:0] rx_q[$];
    int hold_err;

    task automatic collect(input int n, input bit toggle);
        int cyc = 0;
        bit ph = 1'b1;
        bit stalled = 1'b0;
        logic [7:0] held = '0;
        rx_q.delete();
        hold_err = 0;
        while (rx_q.size() < n && cyc < 300) begin
            if (stalled && (!m_tvalid || m_tdata !== held)) hold_err++;
            m_tready = toggle ? ph : 1'b1;
            stalled  = m_tvalid && !m_tready;
            held     = m_tdata;
            if (m_tvalid && m_tready) rx_q.push_back(m_tdata);
            ph = !ph;
            @(negedge clk);
            cyc++;
        end
        m_tready = 1'b0;
        check("rx_count", rx_q.size(), n);
        check("tx_hold", hold_err, 0);
        check("tx_idle_after", m_tvalid, 0);
    endtask

    function automatic logic [63:0] rx_word();
        logic [63:0] r = '0;
        foreach (rx_q[i]) r = (r << 8) | 64'(rx_q[i]);
        return r;
    endfunction

    int cyc;
    int tv_cnt;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {s_tready, m_tvalid, m_tdata, bus.awvalid, bus.wvalid,
                                bus.arvalid, bus.bready, bus.rready}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", s_tready, 1);

        // Write 0xDEADBEEF to 0x43C00004
        send_byte(8'h57); send_word(32'h43C0_0004); send_word(32'hDEAD_BEEF);
        check("wr_latency", {bus.awvalid, bus.wvalid}, 2'b11);
        check("wr_no_tready", s_tready, 0);
        collect(1, 1'b0);
        check("wr_resp", rx_word(), 64'h00);
        check("wr_awaddr", aw_addr_seen, 32'h43C0_0004);
        check("wr_wdata", w_data_seen, 32'hDEAD_BEEF);
        check("wr_wstrb", w_strb_seen, 4'hF);
        check("wr_awprot", aw_prot_seen, 3'b000);
        check("wr_counts", {8'(aw_cnt), 8'(w_cnt), 8'(b_cnt)}, 24'h01_01_01);

        // Read back
        send_byte(8'h52); send_word(32'h43C0_0004);
        check("rd_latency", bus.arvalid, 1);
        collect(5, 1'b0);
        check("rd_resp", rx_word(), 64'h00_DEAD_BEEF);
        check("rd_araddr", ar_addr_seen, 32'h43C0_0004);
        check("rd_arprot", ar_prot_seen, 3'b000);
        check("rd_count", ar_cnt, 1);

        // AW held off 5 cycles after W; SLVERR response
        aw_delay_en = 1'b1; bresp_cfg = 2'b10;
        send_byte(8'h57); send_word(32'h0000_0010); send_word(32'h1234_5678);
        collect(1, 1'b0);
        check("slow_aw_resp", rx_word(), 64'h02);
        check("slow_aw_counts", {8'(aw_cnt), 8'(w_cnt), 8'(b_cnt)}, 24'h02_02_02);
        check("slow_aw_addr", aw_addr_seen, 32'h0000_0010);
        aw_delay_en = 1'b0; bresp_cfg = 2'b00;

        // Unknown opcode, then a read with m_tready toggling
        send_byte(8'h41);
        collect(1, 1'b0);
        check("badop_resp", rx_word(), 64'hEE);
        check("badop_no_axi", aw_cnt + ar_cnt + w_cnt, 5);
        send_byte(8'h52); send_word(32'h0000_0010);
        collect(5, 1'b1);
        check("toggle_rd_resp", rx_word(), 64'h00_1234_5678);

        // Partial frame then stall -> timeout
        send_byte(8'h57); send_byte(8'h43); send_byte(8'hC0);
        collect(1, 1'b0);
        check("timeout_resp", rx_word(), 64'hEF);
        check("timeout_no_axi", {8'(aw_cnt), 8'(w_cnt), 8'(ar_cnt)}, 24'h02_02_02);
        check("timeout_idle", s_tready, 1);

        // Reset while waiting in RDATA
        r_hold = 1'b1;
        send_byte(8'h52); send_word(32'h43C0_0004);
        cyc = 0;
        while (!bus.rready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_rdata", bus.rready, 1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_outputs", {s_tready, m_tvalid, m_tdata, bus.awvalid, bus.wvalid,
                                      bus.arvalid, bus.bready, bus.rready}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; r_hold = 1'b0;
        @(negedge clk);
        check("ready_after_midreset", s_tready, 1);
        m_tready = 1'b1;
        tv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_tvalid) tv_cnt++;
            @(negedge clk);
        end
        m_tready = 1'b0;
        check("no_resp_after_reset", tv_cnt, 0);
        check("no_r_after_reset", r_cnt, 2);

        // Bridge still functional
        send_byte(8'h52); send_word(32'h43C0_0004);
        collect(5, 1'b0);
        check("post_reset_rd", rx_word(), 64'h00_1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/axil_stream_bridge.md
AXIL_STREAM_BRIDGE -- requirements
Module: axil_stream_bridge

Interface
REQ-001 SHALL have parameter AXIL_ADDR_WIDTH, default 32, meaning the AXI-Lite address width (fixed at 32 in this revision).
REQ-002 SHALL have parameter AXIL_DATA_WIDTH, default 32, meaning the AXI-Lite data width (fixed at 32 in this revision).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum idle gap between bytes of one frame.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port s_tdata, input, 8 bits: command byte, for example from UART RX.
REQ-008 SHALL have ports s_tvalid (input, 1 bit) and s_tready (output, 1 bit): the command byte handshake.
REQ-009 SHALL have port m_tdata, output, 8 bits: response byte, for example to UART TX.
REQ-010 SHALL have ports m_tvalid (output, 1 bit) and m_tready (input, 1 bit): the response byte handshake.
REQ-011 SHALL have port m_axil, axil_if master modport, AXIL_ADDR_WIDTH/AXIL_DATA_WIDTH: drives the interconnect slave port of axil_top.

Function
REQ-012 A byte transfer SHALL occur on any clk_i edge where valid and ready are both high.
REQ-013 Frame format: opcode byte, then 4 address bytes MSB first, then, for writes only, 4 data bytes MSB first.
REQ-014 Opcode 0x57 ('W') SHALL select a write; opcode 0x52 ('R') SHALL select a read.
REQ-015 The FSM SHALL have the states IDLE, ADDR, DATA, WR, BRESP, RD, RDATA and TX.
REQ-016 s_tready SHALL be high only in IDLE, ADDR and DATA; the bridge SHALL never accept input bytes while a transaction or response is pending.
REQ-017 IDLE, unknown opcode: the bridge SHALL consume the byte and enter TX with the single response byte 0xEE.
REQ-018 IDLE to ADDR on a valid opcode; ADDR SHALL shift in 4 bytes counted by a 2-bit counter.
REQ-019 After the 4th address byte, a write SHALL go to DATA and a read SHALL go to RD.
REQ-020 DATA SHALL shift in 4 bytes, then go to WR.
REQ-021 WR SHALL assert awvalid and wvalid in the same cycle, with wstrb=4'hF and awprot=arprot=3'b000.
REQ-022 In WR, each valid SHALL drop independently after its own handshake; the FSM SHALL go to BRESP once both handshakes have completed, in either order or simultaneously.
REQ-023 BRESP SHALL assert bready; on bvalid, the response byte SHALL be {6'b0, bresp}, followed by TX.
REQ-024 RD SHALL assert arvalid until arready, then go to RDATA.
REQ-025 RDATA SHALL assert rready; on rvalid, the bridge SHALL latch rdata and rresp and queue 5 response bytes: {6'b0, rresp}, then rdata MSB first.
REQ-026 TX SHALL present queued bytes on m_tdata in order, hold m_tdata and m_tvalid stable while m_tready is low, and return to IDLE after the last handshake.
REQ-027 Timeout: in ADDR or DATA, a counter SHALL clear on each accepted byte and increment otherwise.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES, the partial frame SHALL be discarded and TX SHALL send the single byte 0xEF.
REQ-029 No timeout SHALL apply in WR, BRESP, RD or RDATA; the bridge SHALL wait for the slave indefinitely.
REQ-030 Latency: awvalid/wvalid (or arvalid) SHALL rise on the cycle after the final frame byte is accepted.
REQ-031 The first response byte SHALL become valid on the cycle after the B or R handshake.
REQ-032 Back-to-back frames SHALL be supported: IDLE is re-entered on the cycle after the last TX handshake.

Reset
REQ-033 rst_i high SHALL immediately force IDLE, clear all counters and shift registers, and drive s_tready=0, m_tvalid=0, m_tdata=0, awvalid=wvalid=arvalid=0, bready=rready=0.
REQ-034 On the first clock after rst_i falls, s_tready SHALL be 1.
REQ-035 Reset asserted mid-frame or mid-transaction SHALL abandon the frame without emitting any response byte.

Verification
REQ-036 Write: W 43 C0 00 04 DE AD BE EF -> single AXI write with awaddr=0x43C00004, wdata=0xDEADBEEF, wstrb=F; response 0x00.
REQ-037 Read-back after REQ-036: R 43 C0 00 04 -> araddr=0x43C00004; response 00 DE AD BE EF.
REQ-038 Slave delays awready 5 cycles after wready -> exactly one AW and one W handshake; bresp=2'b10 -> response 0x02.
REQ-039 Opcode 0x41 -> response 0xEE, no AXI activity; the next valid frame succeeds.
REQ-040 TIMEOUT_CYCLES=16, send W 43 C0 then stall 16 cycles -> response 0xEF, no AXI activity.
REQ-041 m_tready toggling 1/0 during a read response -> 5 bytes delivered in order with no loss or duplication.
REQ-042 Reset pulse in RDATA -> all valid/ready outputs low asynchronously; no response byte is emitted.
